// File: rtl/fetch_ctrl_if.sv
// Fetch-side bus: redirect requests, decode stall, instruction-memory handshake
// and the IF/ID outputs, bundled so the sequencer and its environment share one port.
interface fetch_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              Branch;
    logic [DATA_W-1:0] bpc;
    logic              Jump;
    logic [DATA_W-1:0] jpc;
    logic              stall;
    logic              imem_req;
    logic [DATA_W-1:0] imem_addr;
    logic              imem_ready;
    logic [DATA_W-1:0] imem_rdata;
    logic [DATA_W-1:0] IF_Inst;
    logic [DATA_W-1:0] IF_PC;
    logic              if_valid;

    modport master (
        input  Branch, bpc, Jump, jpc, stall, imem_ready, imem_rdata,
        output imem_req, imem_addr, IF_Inst, IF_PC, if_valid
    );

    modport slave (
        output Branch, bpc, Jump, jpc, stall, imem_ready, imem_rdata,
        input  imem_req, imem_addr, IF_Inst, IF_PC, if_valid
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, runs the imem request handshake,
// feeds IF/ID through a one-entry skid buffer and drains killed in-flight requests.
module fetch_ctrl #(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP      = '0
) (
    input logic          clk,
    input logic          reset,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {BOOT, FETCH, HOLD, DRAIN} state_t;

    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(4);

    state_t            state, state_nx;
    logic [DATA_W-1:0] pc, pc_nx;
    logic [DATA_W-1:0] req_addr, req_addr_nx;
    logic [DATA_W-1:0] tgt, tgt_nx;
    logic [DATA_W-1:0] hold_inst, hold_inst_nx;
    logic [DATA_W-1:0] hold_pc, hold_pc_nx;
    logic [DATA_W-1:0] inst_p0, inst_p0_nx;
    logic [DATA_W-1:0] pc_p0, pc_p0_nx;
    logic              vld_p0, vld_p0_nx;

    logic              redirect;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] seq_pc;

    // Branch outranks Jump when both fire in the same cycle.
    assign redirect = bus.Branch | bus.Jump;
    assign target   = bus.Branch ? bus.bpc : bus.jpc;
    assign seq_pc   = req_addr + PC_STEP;

    always_comb begin
        state_nx     = state;
        pc_nx        = pc;
        req_addr_nx  = req_addr;
        tgt_nx       = tgt;
        hold_inst_nx = hold_inst;
        hold_pc_nx   = hold_pc;
        inst_p0_nx   = inst_p0;
        pc_p0_nx     = pc_p0;
        vld_p0_nx    = vld_p0;
        bus.imem_req = 1'b0;

        // A flush always wins over a stall.
        if (redirect) begin
            vld_p0_nx  = 1'b0;
            inst_p0_nx = NOP;
        end

        unique case (state)
            BOOT: begin
                state_nx = FETCH;
                if (redirect) begin
                    pc_nx       = target;
                    req_addr_nx = target;
                end
            end

            FETCH: begin
                bus.imem_req = 1'b1;
                if (redirect) begin
                    if (bus.imem_ready) begin
                        pc_nx       = target;
                        req_addr_nx = target;
                    end else begin
                        tgt_nx   = target;
                        state_nx = DRAIN;
                    end
                end else if (bus.imem_ready) begin
                    pc_nx       = seq_pc;
                    req_addr_nx = seq_pc;
                    if (bus.stall) begin
                        hold_inst_nx = bus.imem_rdata;
                        hold_pc_nx   = req_addr;
                        state_nx     = HOLD;
                    end else begin
                        inst_p0_nx = bus.imem_rdata;
                        pc_p0_nx   = req_addr;
                        vld_p0_nx  = 1'b1;
                    end
                end else if (!bus.stall) begin
                    vld_p0_nx  = 1'b0;
                    inst_p0_nx = NOP;
                end
            end

            HOLD: begin
                if (redirect) begin
                    pc_nx       = target;
                    req_addr_nx = target;
                    state_nx    = FETCH;
                end else if (!bus.stall) begin
                    inst_p0_nx = hold_inst;
                    pc_p0_nx   = hold_pc;
                    vld_p0_nx  = 1'b1;
                    state_nx   = FETCH;
                end
            end

            DRAIN: begin
                // The old request must complete before the new target is issued.
                bus.imem_req = 1'b1;
                if (bus.imem_ready) begin
                    pc_nx       = redirect ? target : tgt;
                    req_addr_nx = redirect ? target : tgt;
                    state_nx    = FETCH;
                end else if (redirect) begin
                    tgt_nx = target;
                end
            end

            default: state_nx = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
            inst_p0  <= NOP;
            pc_p0    <= RESET_PC;
            vld_p0   <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_addr <= req_addr_nx;
            inst_p0  <= inst_p0_nx;
            pc_p0    <= pc_p0_nx;
            vld_p0   <= vld_p0_nx;
        end
    end

    // Skid buffer and drain target carry no state of their own; HOLD/DRAIN qualify them.
    always_ff @(posedge clk) begin
        tgt       <= tgt_nx;
        hold_inst <= hold_inst_nx;
        hold_pc   <= hold_pc_nx;
    end

    assign bus.imem_addr = req_addr;
    assign bus.IF_Inst   = inst_p0;
    assign bus.IF_PC     = pc_p0;
    assign bus.if_valid  = vld_p0;
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch sequencer for the 5-stage pipeline. It owns the PC register and the instruction-memory request handshake, and feeds the IF/ID boundary. It arbitrates the next-PC source among branch, jump and sequential PC+4, honours decode stalls without losing or duplicating instructions, and kills wrong-path fetches, including requests already in flight to a multi-cycle memory.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP, 32'h0000_0000, instruction word presented when if_valid=0
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset)
- Branch  in  1  taken-branch redirect request, single-cycle pulse
- bpc  in  32  branch target; valid when Branch=1
- Jump  in  1  jump redirect request, single-cycle pulse
- jpc  in  32  jump target; valid when Jump=1
- stall  in  1  decode cannot accept a new instruction; IF outputs must hold
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  request address, word aligned
- imem_ready  in  1  memory returns imem_rdata this cycle; sampled only while imem_req=1
- imem_rdata  in  32  returned instruction
- IF_Inst  out  32  instruction to decode
- IF_PC  out  32  address of IF_Inst
- if_valid  out  1  IF_Inst/IF_PC hold a live instruction

## Operation
- Redirect selection follows the pipeline's existing Npc rule. If Branch=1, the target is bpc. Otherwise, if Jump=1, the target is jpc. If both are asserted in the same cycle, Branch wins.
- Registers:
  - pc: next address to fetch.
  - req_addr: drives imem_addr.
  - tgt: latched redirect target.
  - hold_inst and hold_pc: one-entry skid buffer.
  - Output registers for IF_Inst, IF_PC and if_valid.
- States: BOOT, FETCH, HOLD, DRAIN.
- BOOT:
  - imem_req=0.
  - Next cycle goes to FETCH with req_addr=pc=RESET_PC.
- FETCH:
  - imem_req=1.
  - imem_addr=req_addr, which stays stable until imem_ready.
  - On imem_ready with no redirect and stall=0: load the outputs with rdata and req_addr, set if_valid=1, and set pc and req_addr to req_addr+4.
  - On imem_ready with no redirect and stall=1: load the skid buffer, advance pc and req_addr by 4, go to HOLD, and hold the outputs.
  - With imem_ready=0 and stall=0: if_valid←0 (bubble).
  - With imem_ready=0 and stall=1: the outputs hold.
- HOLD:
  - imem_req=0.
  - While stall=1, the outputs hold.
  - When stall=0, move the buffer to the outputs with if_valid=1, then go to FETCH.
- Redirect in any state:
  - Next cycle: if_valid←0 and IF_Inst←NOP, even if stall=1 (a flush overrides a stall).
  - The skid buffer is discarded.
  - In BOOT, HOLD, or FETCH with imem_ready=1: pc=req_addr←target, then go to FETCH.
  - In FETCH with imem_ready=0: tgt←target, then go to DRAIN.
- DRAIN:
  - imem_req=1 with the old req_addr, which stays unchanged.
  - A further redirect overwrites tgt; the newest request wins.
  - On imem_ready: discard rdata, set pc=req_addr←tgt, and go to FETCH. if_valid stays 0.
- Arithmetic: PC+4 is 32-bit modulo. 0xFFFF_FFFC wraps to 0x0000_0000 with no flag. Targets are used as given; bits [1:0] are not checked.

## Timing
- Reset values, forced immediately while reset=0:
  - State BOOT.
  - imem_req=0.
  - imem_addr=pc=RESET_PC.
  - IF_PC=RESET_PC.
  - IF_Inst=NOP.
  - if_valid=0.
  - Skid buffer empty.
- Reset asserted mid-request drops imem_req asynchronously; any late imem_ready is ignored.
- Latency:
  - First imem_req occurs 1 cycle after reset deasserts (BOOT).
  - The instruction appears on the outputs the cycle after its imem_ready.
  - With imem_ready tied 1, throughput is one instruction per cycle.
- Redirect penalty:
  - With zero-wait memory, the target instruction is valid 2 cycles after the redirect pulse.
  - If the redirect arrives with a request outstanding, the penalty is that 2 cycles plus the remaining wait cycles of the old request.
- Handshake: while imem_req=1 and imem_ready=0, imem_addr must not change.
- At most one request is outstanding at a time.

## Test plan
- Release reset with imem_ready=1 and rdata=addr → the valid IF_PC sequence is 0x0, 0x4, 0x8, … starting 2 cycles after release, with no gaps.
- imem_ready asserted every 3rd cycle → imem_addr is stable across the wait cycles, if_valid pulses once per 3 cycles, and the PCs increment by 4.
- stall=1 for 3 cycles, landing on the imem_ready of 0x8 → IF_PC=0x4 holds, imem_req drops, and 0x8 is presented exactly once when stall falls, followed by 0xC.
- Branch=1 with bpc=0x40 while 0x10 is fetched and ready → if_valid=0 next cycle, next imem_addr=0x40, and IF_PC=0x40 is valid 2 cycles after the pulse.
- Branch=1 with bpc=0x80 and Jump=1 with jpc=0x200 in the same cycle, together with stall=1 → flush (if_valid=0) and next fetch at 0x80.
- Jump with jpc=0x100 while 0x20 is outstanding (ready delayed 2 cycles) → DRAIN keeps imem_addr=0x20, the 0x20 data is never valid, and the next request is 0x100; asserting reset during DRAIN instead gives imem_req=0 immediately and a restart at RESET_PC.
